// File: rtl/aes_pkg.sv
// Shared types, constants and helpers for the AES encryption core.
// Provides the FSM state enum, the 128-bit block type, the Rcon table, the S-box and small
// GF(2^8) / word helpers used by the round datapath and the key schedule.
package aes_pkg;

  typedef logic [127:0] block_t;

  typedef enum logic [1:0] {StIdle, StRun, StDone} aes_state_e;

  localparam logic [7:0] RCON [0:9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic int unsigned nr_of(input int unsigned key_bits);
    return key_bits / 32 + 6;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[2047 - 8 * int'(x) -: 8];
  endfunction

  // Out-of-range indices read as zero so the key step never sees X.
  function automatic logic [7:0] rcon_of(input logic [3:0] idx);
    return (idx < 4'd10) ? RCON[idx] : 8'h00;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

endpackage

// File: rtl/aes_key_step.sv
// One key-schedule step over a two-block key window.
// Ports: ka, kb - current window; rcon_byte - round constant; use_rot_rcon - apply
// RotWord and Rcon (otherwise SubWord only); next_ka, next_kb - advanced window.
// AES-128 expands ka from its own last word (kb passes through); AES-256 shifts kb into ka
// and expands ka using the last word of kb.
module aes_key_step import aes_pkg::*; #(
  parameter int unsigned KEY_BITS = 128
) (
  input  logic [127:0] ka,
  input  logic [127:0] kb,
  input  logic [7:0]   rcon_byte,
  input  logic         use_rot_rcon,
  output logic [127:0] next_ka,
  output logic [127:0] next_kb
);
  localparam bit IsAes256 = (KEY_BITS == 256);

  logic [31:0]  last_w, temp_w, w0, w1, w2, w3;
  logic [127:0] expanded;

  always_comb begin
    last_w = IsAes256 ? kb[31:0] : ka[31:0];
    temp_w = use_rot_rcon ? (sub_word({last_w[23:0], last_w[31:24]}) ^ {rcon_byte, 24'h0})
                          : sub_word(last_w);
    w0 = ka[127:96] ^ temp_w;
    w1 = ka[95:64]  ^ w0;
    w2 = ka[63:32]  ^ w1;
    w3 = ka[31:0]   ^ w2;
    expanded = {w0, w1, w2, w3};
    next_ka  = IsAes256 ? kb : expanded;
    next_kb  = IsAes256 ? expanded : kb;
  end
endmodule

// File: rtl/mix_columns.sv
// MixColumns: multiplies each state column by the fixed AES polynomial over GF(2^8).
// Ports: data_i - state in; data_o - mixed state.
module mix_columns import aes_pkg::*; (
  input  block_t data_i,
  output block_t data_o
);
  logic [7:0] a0, a1, a2, a3;

  always_comb begin
    data_o = '0;
    a0 = '0; a1 = '0; a2 = '0; a3 = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = data_i[127 - 32 * c -: 8];
      a1 = data_i[119 - 32 * c -: 8];
      a2 = data_i[111 - 32 * c -: 8];
      a3 = data_i[103 - 32 * c -: 8];
      // 3*x is xtime(x) ^ x.
      data_o[127 - 32 * c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      data_o[119 - 32 * c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      data_o[111 - 32 * c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      data_o[103 - 32 * c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
  end
endmodule

// File: rtl/shift_rows.sv
// ShiftRows: row r of the column-major state rotates left by r bytes.
// Ports: data_i - state in; data_o - shifted state.
module shift_rows import aes_pkg::*; (
  input  block_t data_i,
  output block_t data_o
);
  always_comb begin
    data_o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        // Byte index is r + 4c; source column is (c + r) mod 4.
        data_o[127 - 8 * (r + 4 * c) -: 8] = data_i[127 - 8 * (r + 4 * ((c + r) % 4)) -: 8];
      end
    end
  end
endmodule

// File: rtl/sub_bytes.sv
// SubBytes: applies the AES S-box to each of the 16 state bytes.
// Ports: data_i - state in; data_o - substituted state.
module sub_bytes import aes_pkg::*; (
  input  block_t data_i,
  output block_t data_o
);
  always_comb begin
    data_o = '0;
    for (int i = 0; i < 16; i++) begin
      data_o[127 - 8 * i -: 8] = sbox(data_i[127 - 8 * i -: 8]);
    end
  end
endmodule

// File: rtl/aes_core.sv
// Multicycle AES encryption core, one round per clock, AES-128 or AES-256 by KEY_BITS.
// Ports: clk, rst_n (synchronous, active low); in_valid/in_ready/in_data/in_key - block input
// handshake; out_valid/out_ready/out_data - ciphertext output handshake with a held result;
// busy - a block is being processed.
// Round 1 is computed on the accept edge, so out_valid rises after edge NR counting the
// accept edge as 1. A pop and a new accept may share one edge.
module aes_core import aes_pkg::*; #(
  parameter int unsigned KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [127:0]        in_data,
  input  logic [KEY_BITS-1:0] in_key,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        out_data,
  output logic                busy
);
  localparam int unsigned NR       = nr_of(KEY_BITS);
  localparam bit          IsAes256 = (KEY_BITS == 256);
  localparam logic [3:0]  LastCnt  = 4'(NR - 1);

  if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key_bits
    $error("aes_core: KEY_BITS must be 128 or 256");
  end

  aes_state_e   state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  block_t       data_q, data_d, out_q, out_d;
  logic [127:0] ka_q, ka_d, kb_q, kb_d;

  logic         accept, last_round, use_rot;
  logic [3:0]   rcon_idx;
  logic [127:0] key_hi, key_lo, ks_ka, next_ka, next_kb, round_key;
  block_t       round_in, sb_out, sr_out, mc_out, round_out;

  assign in_ready   = (state_q == StIdle) || ((state_q == StDone) && out_ready);
  assign out_valid  = (state_q == StDone);
  assign busy       = (state_q == StRun);
  assign out_data   = out_q;
  assign accept     = in_valid && in_ready;
  assign last_round = (state_q == StRun) && (cnt_q == LastCnt);

  assign key_hi = in_key[KEY_BITS-1 -: 128];
  assign key_lo = in_key[127:0];

  // AES-128 needs rk1 on the accept edge, so the step then runs on the incoming key.
  // AES-256 alternates Rcon/SubWord-only steps; Rcon advances every second step.
  assign ks_ka    = accept ? key_hi : ka_q;
  assign rcon_idx = IsAes256 ? {1'b0, cnt_q[3:1]} : (accept ? 4'd0 : cnt_q);
  assign use_rot  = IsAes256 ? cnt_q[0] : 1'b1;

  aes_key_step #(.KEY_BITS(KEY_BITS)) u_key_step (
    .ka          (ks_ka),
    .kb          (kb_q),
    .rcon_byte   (rcon_of(rcon_idx)),
    .use_rot_rcon(use_rot),
    .next_ka     (next_ka),
    .next_kb     (next_kb)
  );

  assign round_key = accept ? (IsAes256 ? key_lo : next_ka) : (IsAes256 ? next_kb : next_ka);
  assign round_in  = accept ? (in_data ^ key_hi) : data_q;

  sub_bytes u_sub_bytes (
    .data_i(round_in),
    .data_o(sb_out)
  );

  shift_rows u_shift_rows (
    .data_i(sb_out),
    .data_o(sr_out)
  );

  mix_columns u_mix_columns (
    .data_i(sr_out),
    .data_o(mc_out)
  );

  // Final round skips MixColumns.
  assign round_out = (last_round ? sr_out : mc_out) ^ round_key;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    out_d   = out_q;
    ka_d    = ka_q;
    kb_d    = kb_q;
    unique case (state_q)
      StIdle: ;
      StRun: begin
        data_d = round_out;
        ka_d   = next_ka;
        kb_d   = next_kb;
        cnt_d  = cnt_q + 4'd1;
        if (last_round) begin
          out_d   = round_out;
          state_d = StDone;
        end
      end
      StDone: if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // Accept from IDLE or together with a pop in DONE.
    if (accept) begin
      data_d  = round_out;
      ka_d    = IsAes256 ? key_hi : next_ka;
      kb_d    = IsAes256 ? key_lo : '0;
      cnt_d   = 4'd1;
      state_d = StRun;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      data_q  <= '0;
      out_q   <= '0;
      ka_q    <= '0;
      kb_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      out_q   <= out_d;
      ka_q    <= ka_d;
      kb_q    <= kb_d;
    end
  end
endmodule
